multrs: RTL and testbench
=========================

# multrs

Reservation station feeding the multiply functional unit. Accepts dispatched multiply micro-ops with up to two source operands, holds them in `DEPTH` entries while any operand waits on a producer, snoops the CDB to capture results by ROB id, and issues the oldest fully-ready entry to the multiplier when it is not busy. It sits between the dispatch/rename stage and the multiplier FU.

## Interface
Parameters:
- `DEPTH`, 4: number of entries, 2..8.

Ports:
- `clk` in 1: single clock, all state on rising edge.
- `rst` in 1: reset, asynchronous and active-high; clears all entries and registered outputs.
- `flush` in 1: synchronous squash of every entry.
- `disp_valid` in 1: dispatch request this cycle.
- `disp_operand` in 8: opcode/operand byte, passed through.
- `disp_ready` in 2: per-source operand already valid.
- `disp_tags` in 2x4: per-source producer ROB id, used when not ready.
- `disp_vals` in 2x8: per-source value, used when ready.
- `disp_wbs` in 8, `disp_flags` in 8, `disp_robid` in 4: passed through to the FU.
- `disp_full` out 1: no free entry; dispatch is ignored while high.
- `cdb_valid` in 1, `cdb_id` in 4, `cdb_val` in 8: result broadcast to snoop.
- `fu_busy` in 1: multiplier busy flag.
- `input_transmit` out 1: one-cycle issue pulse to the FU.
- `operand` out 8, `depvals` out 2x8, `wbs` out 8, `flags` out 8, `robid` out 4: issued payload, registered and valid while `input_transmit` is high.

## Operation
- Entry state: valid, per-source rdy/tag/val, payload, age stamp.
- Dispatch: if `disp_valid && !disp_full && !flush`, write the lowest-index free entry.
- Dispatch bypass: if a source is not ready, `cdb_valid` is high and `cdb_id` equals its tag in the same cycle, the source is written ready with `cdb_val`.
- Snoop: every valid entry source with rdy=0 and tag==`cdb_id` captures `cdb_val` and sets rdy when `cdb_valid` is high. Multiple entries and both sources may match in one cycle.
- Ready entry: valid with both rdy bits set, taken from registered state at the start of the cycle. A capture in cycle t makes the entry eligible at t+1.
- Selection: the oldest ready entry by dispatch order. Age is a 4-bit wrapping stamp compared modulo against the oldest live stamp, or an equivalent age matrix. Ties are impossible.
- Issue condition: a ready entry exists, `!fu_busy`, `!input_transmit` (the FU busy flag lags the issue pulse by one cycle), and `!flush`.
- On issue: load the payload registers, pulse `input_transmit` for one cycle, and free the entry at the same edge.
- `disp_full` = (live count == DEPTH), registered count. An entry freed by issue accepts a dispatch only from the next cycle.
- Flush: at the next edge all entries are invalid, `input_transmit` is 0, count is 0. Flush takes priority over dispatch, snoop and issue.
- Dispatch, snoop and issue in one cycle are all honoured independently. The issued entry is never the newly dispatched one.

## Timing
- Reset values: `input_transmit` 0, `operand`/`depvals`/`wbs`/`flags`/`robid` 0, `disp_full` 0, all entries invalid.
- Reset mid-operation: all entries and any pending pulse are dropped immediately (asynchronous).
- Minimum latency:
  - With both sources ready at dispatch in cycle t, `input_transmit` rises at t+1.
  - A source satisfied by CDB in cycle t issues no earlier than t+2.
- Maximum issue rate is one per two cycles. In practice it is limited by `fu_busy`.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- Ready dispatch: `disp_ready`=11, vals 0x05/0x07, robid 3, FU idle. Expect `input_transmit` one cycle later with depvals 0x05/0x07 and robid 3, then an empty station.
- CDB wakeup: dispatch with src1 tag 9 not ready, src0=0x03. Two cycles later `cdb_id`=9, `cdb_val`=0x0A. Expect issue exactly 2 cycles after the broadcast with depvals 0x03/0x0A.
- Same-cycle bypass: dispatch a source with tag 4 while `cdb_id`=4, `cdb_val`=0x11. Expect the entry ready and issued the next cycle with 0x11.
- Full and ordering: dispatch 4 ready entries (robid 1..4) with `fu_busy` held high. Expect `disp_full`=1 and a 5th dispatch dropped. Release `fu_busy` and model the FU (busy 9 cycles per issue). Expect issue order 1,2,3,4, each pulse one cycle, never while busy.
- Out-of-order readiness: dispatch A (waits on tag 2), then B (ready). Expect B issued first. Broadcast tag 2, then expect A issued.
- Flush and reset: fill 3 entries and assert `flush` in the same cycle as an eligible issue. Expect no pulse, count 0, `disp_full` 0. Assert `rst` mid-pulse and expect all outputs 0 immediately.

Source files
------------

// File: rtl/multrs_if.sv
// Dispatch, CDB snoop and FU issue bundle for the multiply reservation station.
// The master side is the pipeline around the station; the slave side is the station.
interface multrs_if;
   logic            disp_valid;
   logic [7:0]      disp_operand;
   logic [1:0]      disp_ready;
   logic [1:0][3:0] disp_tags;
   logic [1:0][7:0] disp_vals;
   logic [7:0]      disp_wbs;
   logic [7:0]      disp_flags;
   logic [3:0]      disp_robid;
   logic            disp_full;

   logic            cdb_valid;
   logic [3:0]      cdb_id;
   logic [7:0]      cdb_val;

   logic            fu_busy;
   logic            input_transmit;
   logic [7:0]      operand;
   logic [1:0][7:0] depvals;
   logic [7:0]      wbs;
   logic [7:0]      flags;
   logic [3:0]      robid;

   modport master (
      output disp_valid, disp_operand, disp_ready, disp_tags, disp_vals,
             disp_wbs, disp_flags, disp_robid,
      output cdb_valid, cdb_id, cdb_val,
      output fu_busy,
      input  disp_full,
      input  input_transmit, operand, depvals, wbs, flags, robid
   );

   modport slave (
      input  disp_valid, disp_operand, disp_ready, disp_tags, disp_vals,
             disp_wbs, disp_flags, disp_robid,
      input  cdb_valid, cdb_id, cdb_val,
      input  fu_busy,
      output disp_full,
      output input_transmit, operand, depvals, wbs, flags, robid
   );
endinterface

// File: rtl/multrs.sv
// Multiply-unit reservation station: holds dispatched micro-ops until both
// sources are captured, then issues the oldest ready one to an idle multiplier.
module multrs #(
   parameter int DEPTH = 4
) (
   input  logic   clk,
   input  logic   rst,
   input  logic   flush,
   multrs_if.slave bus
);
   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   // entry control state
   logic [DEPTH-1:0] vld_q, vld_d;
   logic [1:0]       rdy_q [DEPTH];
   logic [1:0]       rdy_d [DEPTH];
   logic [DEPTH-1:0] older_q [DEPTH];
   logic [DEPTH-1:0] older_d [DEPTH];
   logic [CW-1:0]    count_q, count_d;
   logic             full_q, full_d;

   // entry data state
   logic [1:0][3:0]  tag_q [DEPTH];
   logic [1:0][7:0]  val_q [DEPTH];
   logic [1:0][7:0]  val_d [DEPTH];
   logic [7:0]       op_q  [DEPTH];
   logic [7:0]       wb_q  [DEPTH];
   logic [7:0]       fl_q  [DEPTH];
   logic [3:0]       rob_q [DEPTH];

   // registered CDB, snooped one cycle after broadcast
   logic             cdb_vld_q;
   logic [3:0]       cdb_id_q;
   logic [7:0]       cdb_val_q;

   // issue output registers
   logic             xmit_q, xmit_d;
   logic [7:0]       operand_q, operand_d;
   logic [1:0][7:0]  depvals_q, depvals_d;
   logic [7:0]       wbs_q, wbs_d;
   logic [7:0]       flags_q, flags_d;
   logic [3:0]       robid_q, robid_d;

   logic [DEPTH-1:0] ready_vec;
   logic [DEPTH-1:0] blocked_vec;
   logic             free_found;
   logic [IW-1:0]    free_idx;
   logic             sel_found;
   logic [IW-1:0]    sel_idx;
   logic             acc;
   logic             iss;
   logic [1:0]       byp_now;
   logic [1:0]       byp_old;
   logic [1:0]       src_rdy;
   logic [1:0][7:0]  src_val;

   always_comb begin
      ready_vec   = '0;
      blocked_vec = '0;
      free_found  = 1'b0;
      free_idx    = '0;
      sel_found   = 1'b0;
      sel_idx     = '0;

      for (int i = 0; i < DEPTH; i++) begin
         ready_vec[i] = vld_q[i] & rdy_q[i][0] & rdy_q[i][1];
      end

      // an entry is blocked when any other ready entry is older than it
      for (int i = 0; i < DEPTH; i++) begin
         for (int j = 0; j < DEPTH; j++) begin
            if (ready_vec[j] && older_q[j][i]) begin
               blocked_vec[i] = 1'b1;
            end
         end
      end

      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (!vld_q[i]) begin
            free_found = 1'b1;
            free_idx   = IW'(i);
         end
         if (ready_vec[i] && !blocked_vec[i]) begin
            sel_found = 1'b1;
            sel_idx   = IW'(i);
         end
      end

      acc = bus.disp_valid && !full_q && !flush && free_found;
      iss = sel_found && !bus.fu_busy && !xmit_q && !flush;

      for (int s = 0; s < 2; s++) begin
         byp_now[s] = bus.cdb_valid && (bus.cdb_id == bus.disp_tags[s]);
         byp_old[s] = cdb_vld_q && (cdb_id_q == bus.disp_tags[s]);
         src_rdy[s] = bus.disp_ready[s] | byp_now[s] | byp_old[s];
         if (bus.disp_ready[s]) begin
            src_val[s] = bus.disp_vals[s];
         end else if (byp_now[s]) begin
            src_val[s] = bus.cdb_val;
         end else begin
            src_val[s] = cdb_val_q;
         end
      end
   end

   always_comb begin
      vld_d     = vld_q;
      rdy_d     = rdy_q;
      val_d     = val_q;
      older_d   = older_q;
      xmit_d    = 1'b0;
      operand_d = operand_q;
      depvals_d = depvals_q;
      wbs_d     = wbs_q;
      flags_d   = flags_q;
      robid_d   = robid_q;

      for (int i = 0; i < DEPTH; i++) begin
         for (int s = 0; s < 2; s++) begin
            if (vld_q[i] && !rdy_q[i][s] && cdb_vld_q && (tag_q[i][s] == cdb_id_q)) begin
               rdy_d[i][s] = 1'b1;
               val_d[i][s] = cdb_val_q;
            end
         end
      end

      if (iss) begin
         vld_d[sel_idx] = 1'b0;
         xmit_d         = 1'b1;
         operand_d      = op_q[sel_idx];
         depvals_d      = val_q[sel_idx];
         wbs_d          = wb_q[sel_idx];
         flags_d        = fl_q[sel_idx];
         robid_d        = rob_q[sel_idx];
      end

      // every live entry is older than the one being written
      if (acc) begin
         vld_d[free_idx]   = 1'b1;
         rdy_d[free_idx]   = src_rdy;
         val_d[free_idx]   = src_val;
         older_d[free_idx] = '0;
         for (int j = 0; j < DEPTH; j++) begin
            older_d[j][free_idx] = vld_q[j];
         end
      end

      if (flush) begin
         vld_d  = '0;
         xmit_d = 1'b0;
      end

      if (flush) begin
         count_d = '0;
      end else if (acc && !iss) begin
         count_d = count_q + 1'b1;
      end else if (iss && !acc) begin
         count_d = count_q - 1'b1;
      end else begin
         count_d = count_q;
      end
      full_d = (count_d == CW'(DEPTH));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_q     <= '0;
         count_q   <= '0;
         full_q    <= 1'b0;
         cdb_vld_q <= 1'b0;
         xmit_q    <= 1'b0;
         operand_q <= '0;
         depvals_q <= '0;
         wbs_q     <= '0;
         flags_q   <= '0;
         robid_q   <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            rdy_q[i]   <= '0;
            older_q[i] <= '0;
         end
      end else begin
         vld_q     <= vld_d;
         rdy_q     <= rdy_d;
         older_q   <= older_d;
         count_q   <= count_d;
         full_q    <= full_d;
         cdb_vld_q <= bus.cdb_valid;
         xmit_q    <= xmit_d;
         operand_q <= operand_d;
         depvals_q <= depvals_d;
         wbs_q     <= wbs_d;
         flags_q   <= flags_d;
         robid_q   <= robid_d;
      end
   end

   always_ff @(posedge clk) begin
      cdb_id_q  <= bus.cdb_id;
      cdb_val_q <= bus.cdb_val;
      val_q     <= val_d;
      if (acc) begin
         tag_q[free_idx] <= bus.disp_tags;
         op_q[free_idx]  <= bus.disp_operand;
         wb_q[free_idx]  <= bus.disp_wbs;
         fl_q[free_idx]  <= bus.disp_flags;
         rob_q[free_idx] <= bus.disp_robid;
      end
   end

   assign bus.disp_full      = full_q;
   assign bus.input_transmit = xmit_q;
   assign bus.operand        = operand_q;
   assign bus.depvals        = depvals_q;
   assign bus.wbs            = wbs_q;
   assign bus.flags          = flags_q;
   assign bus.robid          = robid_q;
endmodule

// File: tb/tb_multrs.sv
// Directed bench for the multiply reservation station: a vector table of
// single-op dispatches plus hand-built wakeup, ordering, flush and reset sequences.
module tb_multrs;
   logic clk;
   logic rst;
   logic flush;
   int   total;
   int   bad;

   multrs_if bus ();

   multrs #(.DEPTH(4)) dut (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [1:0] rdy;
      logic [3:0] t0;
      logic [3:0] t1;
      logic [7:0] v0;
      logic [7:0] v1;
      logic [7:0] op;
      logic [7:0] wb;
      logic [7:0] fl;
      logic [3:0] rob;
      logic       cv;
      logic [3:0] cid;
      logic [7:0] cval;
      logic [7:0] e0;
      logic [7:0] e1;
   } vec_t;

   vec_t tbl [5];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic disp(input logic [1:0] rdy, input logic [3:0] t0, input logic [3:0] t1,
                       input logic [7:0] v0, input logic [7:0] v1, input logic [3:0] rob);
      bus.disp_valid   = 1'b1;
      bus.disp_ready   = rdy;
      bus.disp_tags[0] = t0;
      bus.disp_tags[1] = t1;
      bus.disp_vals[0] = v0;
      bus.disp_vals[1] = v1;
      bus.disp_operand = {4'hA, rob};
      bus.disp_wbs     = {4'h5, rob};
      bus.disp_flags   = {rob, 4'h3};
      bus.disp_robid   = rob;
      step();
      bus.disp_valid   = 1'b0;
   endtask

   int   nseen;
   int   busy_cnt;
   logic start_pending;
   logic prev_x;
   logic busy_at_edge;
   logic [3:0] exp_rob;

   initial begin
      total = 0;
      bad   = 0;
      tbl[0] = '{2'b11, 4'h0, 4'h0, 8'h05, 8'h07, 8'h2A, 8'h10, 8'h01, 4'd3,
                 1'b0, 4'h0, 8'h00, 8'h05, 8'h07};
      tbl[1] = '{2'b01, 4'h0, 4'h4, 8'h22, 8'h00, 8'h31, 8'h11, 8'h02, 4'd7,
                 1'b1, 4'h4, 8'h11, 8'h22, 8'h11};
      tbl[2] = '{2'b10, 4'hC, 4'h0, 8'h00, 8'h99, 8'h44, 8'h12, 8'h04, 4'd9,
                 1'b1, 4'hC, 8'h5A, 8'h5A, 8'h99};
      tbl[3] = '{2'b00, 4'h6, 4'h6, 8'h00, 8'h00, 8'h55, 8'h13, 8'h08, 4'd11,
                 1'b1, 4'h6, 8'h3C, 8'h3C, 8'h3C};
      tbl[4] = '{2'b11, 4'h7, 4'h7, 8'hFF, 8'h80, 8'h66, 8'h14, 8'h10, 4'd15,
                 1'b1, 4'h7, 8'h01, 8'hFF, 8'h80};

      rst = 1'b1;
      flush = 1'b0;
      bus.disp_valid = 1'b0;
      bus.disp_ready = 2'b00;
      bus.disp_tags = '0;
      bus.disp_vals = '0;
      bus.disp_operand = '0;
      bus.disp_wbs = '0;
      bus.disp_flags = '0;
      bus.disp_robid = '0;
      bus.cdb_valid = 1'b0;
      bus.cdb_id = '0;
      bus.cdb_val = '0;
      bus.fu_busy = 1'b0;
      step();
      step();
      chk("rst_xmit", bus.input_transmit, 1'b0);
      chk("rst_full", bus.disp_full, 1'b0);
      chk("rst_payload", {bus.operand, bus.depvals, bus.wbs, bus.flags, bus.robid}, 0);
      rst = 1'b0;
      step();

      // single dispatches, ready or bypassed from the same-cycle CDB
      for (int k = 0; k < 5; k++) begin
         bus.disp_valid   = 1'b1;
         bus.disp_ready   = tbl[k].rdy;
         bus.disp_tags[0] = tbl[k].t0;
         bus.disp_tags[1] = tbl[k].t1;
         bus.disp_vals[0] = tbl[k].v0;
         bus.disp_vals[1] = tbl[k].v1;
         bus.disp_operand = tbl[k].op;
         bus.disp_wbs     = tbl[k].wb;
         bus.disp_flags   = tbl[k].fl;
         bus.disp_robid   = tbl[k].rob;
         bus.cdb_valid    = tbl[k].cv;
         bus.cdb_id       = tbl[k].cid;
         bus.cdb_val      = tbl[k].cval;
         step();
         bus.disp_valid = 1'b0;
         bus.cdb_valid  = 1'b0;
         chk($sformatf("v%0d_early", k), bus.input_transmit, 1'b0);
         step();
         chk($sformatf("v%0d_xmit", k), bus.input_transmit, 1'b1);
         chk($sformatf("v%0d_dep0", k), bus.depvals[0], tbl[k].e0);
         chk($sformatf("v%0d_dep1", k), bus.depvals[1], tbl[k].e1);
         chk($sformatf("v%0d_pay", k), {bus.operand, bus.wbs, bus.flags, bus.robid},
             {tbl[k].op, tbl[k].wb, tbl[k].fl, tbl[k].rob});
         step();
         chk($sformatf("v%0d_pulse1", k), bus.input_transmit, 1'b0);
         step();
         chk($sformatf("v%0d_empty", k), {bus.input_transmit, bus.disp_full}, 2'b00);
      end

      // CDB wakeup of a parked source: issue two cycles after the broadcast
      disp(2'b01, 4'h0, 4'h9, 8'h03, 8'h00, 4'd2);
      chk("wk_wait0", bus.input_transmit, 1'b0);
      step();
      chk("wk_wait1", bus.input_transmit, 1'b0);
      bus.cdb_valid = 1'b1;
      bus.cdb_id    = 4'h9;
      bus.cdb_val   = 8'h0A;
      step();
      bus.cdb_valid = 1'b0;
      chk("wk_t0", bus.input_transmit, 1'b0);
      step();
      chk("wk_t1", bus.input_transmit, 1'b0);
      step();
      chk("wk_t2", bus.input_transmit, 1'b1);
      chk("wk_dep", bus.depvals, {8'h0A, 8'h03});
      chk("wk_rob", bus.robid, 4'd2);
      step();
      step();

      // fill with the FU busy, then drain through a modelled multiplier
      bus.fu_busy = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         chk($sformatf("full_before%0d", k), bus.disp_full, 1'b0);
         disp(2'b11, 4'h0, 4'h0, 8'h10 + 8'(k), 8'h20 + 8'(k), 4'(k));
      end
      chk("full_set", bus.disp_full, 1'b1);
      chk("full_noissue", bus.input_transmit, 1'b0);
      disp(2'b11, 4'h0, 4'h0, 8'hEE, 8'hEE, 4'd5);
      chk("full_hold", bus.disp_full, 1'b1);

      bus.fu_busy   = 1'b0;
      nseen         = 0;
      busy_cnt      = 0;
      start_pending = 1'b0;
      prev_x        = 1'b0;
      for (int c = 0; c < 80; c++) begin
         busy_at_edge = bus.fu_busy;
         step();
         if (bus.input_transmit) begin
            chk("ord_legal", {busy_at_edge, prev_x}, 2'b00);
            exp_rob = 4'(nseen + 1);
            chk("ord_rob", bus.robid, exp_rob);
            chk("ord_dep0", bus.depvals[0], 8'h10 + 8'(nseen + 1));
            nseen++;
         end
         prev_x = bus.input_transmit;
         if (start_pending) begin
            bus.fu_busy   = 1'b1;
            busy_cnt      = 9;
            start_pending = 1'b0;
         end else if (busy_cnt > 0) begin
            busy_cnt--;
            if (busy_cnt == 0) bus.fu_busy = 1'b0;
         end
         if (bus.input_transmit) start_pending = 1'b1;
      end
      chk("ord_count", nseen, 4);
      bus.fu_busy = 1'b0;
      step();

      // out-of-order readiness: younger ready op overtakes a waiting one
      disp(2'b01, 4'h0, 4'h2, 8'h12, 8'h00, 4'd5);
      disp(2'b11, 4'h0, 4'h0, 8'h21, 8'h31, 4'd6);
      chk("ooo_wait", bus.input_transmit, 1'b0);
      step();
      chk("ooo_b_xmit", bus.input_transmit, 1'b1);
      chk("ooo_b_rob", bus.robid, 4'd6);
      chk("ooo_b_dep", bus.depvals, {8'h31, 8'h21});
      step();
      chk("ooo_gap", bus.input_transmit, 1'b0);
      bus.cdb_valid = 1'b1;
      bus.cdb_id    = 4'h2;
      bus.cdb_val   = 8'h44;
      step();
      bus.cdb_valid = 1'b0;
      chk("ooo_a_t0", bus.input_transmit, 1'b0);
      step();
      chk("ooo_a_t1", bus.input_transmit, 1'b0);
      step();
      chk("ooo_a_xmit", bus.input_transmit, 1'b1);
      chk("ooo_a_rob", bus.robid, 4'd5);
      chk("ooo_a_dep", bus.depvals, {8'h44, 8'h12});
      step();
      step();

      // flush beats an eligible issue and a same-cycle dispatch
      bus.fu_busy = 1'b1;
      disp(2'b11, 4'h0, 4'h0, 8'h01, 8'h02, 4'd8);
      disp(2'b11, 4'h0, 4'h0, 8'h03, 8'h04, 4'd9);
      disp(2'b11, 4'h0, 4'h0, 8'h05, 8'h06, 4'd10);
      chk("fl_notfull", bus.disp_full, 1'b0);
      bus.fu_busy = 1'b0;
      flush = 1'b1;
      disp(2'b11, 4'h0, 4'h0, 8'h07, 8'h08, 4'd13);
      flush = 1'b0;
      chk("fl_nopulse", bus.input_transmit, 1'b0);
      chk("fl_full", bus.disp_full, 1'b0);
      for (int c = 0; c < 3; c++) begin
         step();
         chk($sformatf("fl_empty%0d", c), bus.input_transmit, 1'b0);
      end
      bus.fu_busy = 1'b1;
      disp(2'b11, 4'h0, 4'h0, 8'h51, 8'h61, 4'd1);
      disp(2'b11, 4'h0, 4'h0, 8'h52, 8'h62, 4'd2);
      disp(2'b11, 4'h0, 4'h0, 8'h53, 8'h63, 4'd3);
      chk("fl_count3", bus.disp_full, 1'b0);
      disp(2'b11, 4'h0, 4'h0, 8'h54, 8'h64, 4'd4);
      chk("fl_count4", bus.disp_full, 1'b1);

      // asynchronous reset in the middle of an issue pulse
      bus.fu_busy = 1'b0;
      step();
      chk("rs_pulse", bus.input_transmit, 1'b1);
      chk("rs_rob", bus.robid, 4'd1);
      rst = 1'b1;
      #1;
      chk("rs_xmit", bus.input_transmit, 1'b0);
      chk("rs_full", bus.disp_full, 1'b0);
      chk("rs_payload", {bus.operand, bus.depvals, bus.wbs, bus.flags, bus.robid}, 0);
      #2;
      rst = 1'b0;
      for (int c = 0; c < 3; c++) begin
         step();
         chk($sformatf("rs_dropped%0d", c), {bus.input_transmit, bus.disp_full}, 2'b00);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
